// File: rtl/life_pattern_loader.sv
// life_pattern_loader
// Sequencer wrapped around a 4x4 Life array. It accepts a 16-bit seed and a
// generation count, writes the seed into the array one cell per clock, runs
// the array for the requested number of generations, then returns the final
// pattern together with a flag telling whether the last generation equalled
// the one before it.
//
// Handshakes: a transfer happens on the rising edge where valid && ready are
// both high. The seed side (pat_valid/pat_ready) is only ready in IDLE, and
// pat_valid is ignored otherwise. The result side (res_valid/res_ready) holds
// res_valid, res_data and res_stable steady until res_ready is seen.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   pat_valid/pat_data/pat_gens/pat_ready  seed input handshake
//   arr_row/arr_col/arr_val/arr_write_enb  array cell write port
//   arr_run                  array run enable (one generation per clock)
//   arr_alive                array state, bit 4*col+row is cell (row,col)
//   res_valid/res_data/res_stable/res_ready  result output handshake
//   busy                     high whenever the FSM is not in IDLE
//   dbg_state                current FSM state, for observation only
module life_pattern_loader #(
    parameter int GENS_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pat_valid,
    input  logic [15:0]       pat_data,
    input  logic [GENS_W-1:0] pat_gens,
    output logic              pat_ready,
    output logic [1:0]        arr_row,
    output logic [1:0]        arr_col,
    output logic              arr_val,
    output logic              arr_write_enb,
    output logic              arr_run,
    input  logic [15:0]       arr_alive,
    output logic              res_valid,
    output logic [15:0]       res_data,
    output logic              res_stable,
    input  logic              res_ready,
    output logic              busy,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WRITE   = 3'd1,
        S_SETTLE  = 3'd2,
        S_RUN     = 3'd3,
        S_CAPTURE = 3'd4,
        S_RESULT  = 3'd5
    } state_t;

    state_t            r_state;
    logic [15:0]       r_pat_q;
    logic [15:0]       r_prev_q;
    logic [GENS_W-1:0] r_gens_q;
    logic [GENS_W-1:0] r_cnt;
    logic [3:0]        r_k;

    logic              r_pat_ready;
    logic [1:0]        r_arr_row;
    logic [1:0]        r_arr_col;
    logic              r_arr_val;
    logic              r_arr_write_enb;
    logic              r_arr_run;
    logic              r_res_valid;
    logic [15:0]       r_res_data;
    logic              r_res_stable;
    logic              r_busy;

    logic [3:0]        w_k_next;
    assign w_k_next = r_k + 4'd1;

    // All outputs are registered, so each state sets up the outputs that
    // belong to the state it is about to enter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            r_pat_q         <= '0;
            r_prev_q        <= '0;
            r_gens_q        <= '0;
            r_cnt           <= '0;
            r_k             <= '0;
            r_pat_ready     <= 1'b1;
            r_arr_row       <= '0;
            r_arr_col       <= '0;
            r_arr_val       <= 1'b0;
            r_arr_write_enb <= 1'b0;
            r_arr_run       <= 1'b0;
            r_res_valid     <= 1'b0;
            r_res_data      <= '0;
            r_res_stable    <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (pat_valid) begin
                        r_pat_q         <= pat_data;
                        r_gens_q        <= pat_gens;
                        r_k             <= '0;
                        // Present cell k=0 during the first WRITE cycle.
                        r_arr_write_enb <= 1'b1;
                        r_arr_row       <= 2'd0;
                        r_arr_col       <= 2'd0;
                        r_arr_val       <= pat_data[0];
                        r_pat_ready     <= 1'b0;
                        r_busy          <= 1'b1;
                        r_state         <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (r_k == 4'd15) begin
                        r_arr_write_enb <= 1'b0;
                        r_arr_row       <= '0;
                        r_arr_col       <= '0;
                        r_arr_val       <= 1'b0;
                        r_state         <= S_SETTLE;
                    end else begin
                        r_k       <= w_k_next;
                        r_arr_row <= w_k_next[1:0];
                        r_arr_col <= w_k_next[3:2];
                        r_arr_val <= r_pat_q[w_k_next];
                    end
                end
                S_SETTLE: begin
                    r_cnt <= r_gens_q;
                    if (r_gens_q != '0) begin
                        r_arr_run <= 1'b1;
                        r_state   <= S_RUN;
                    end else begin
                        r_state   <= S_CAPTURE;
                    end
                end
                S_RUN: begin
                    // prev_q ends up holding generation N-1 on the last edge.
                    r_prev_q <= arr_alive;
                    r_cnt    <= r_cnt - GENS_W'(1);
                    if (r_cnt == GENS_W'(1)) begin
                        r_arr_run <= 1'b0;
                        r_state   <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    r_res_data   <= arr_alive;
                    r_res_stable <= (r_gens_q != '0) && (arr_alive == r_prev_q);
                    r_res_valid  <= 1'b1;
                    r_state      <= S_RESULT;
                end
                S_RESULT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_pat_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign pat_ready     = r_pat_ready;
    assign arr_row       = r_arr_row;
    assign arr_col       = r_arr_col;
    assign arr_val       = r_arr_val;
    assign arr_write_enb = r_arr_write_enb;
    assign arr_run       = r_arr_run;
    assign res_valid     = r_res_valid;
    assign res_data      = r_res_data;
    assign res_stable    = r_res_stable;
    assign busy          = r_busy;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_life_pattern_loader.sv
// Bench for life_pattern_loader: a behavioural 4x4 Life array sits on the
// array port, a driver issues seeds, and a monitor compares every returned
// result against a queue of expected values.
module tb_life_pattern_loader;

    localparam int W = 41; // {gens[40:33], seed[32:17], stable[16], data[15:0]}

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pat_valid = 1'b0;
    logic [15:0] pat_data = '0;
    logic [7:0]  pat_gens = '0;
    logic        pat_ready;
    logic [1:0]  arr_row;
    logic [1:0]  arr_col;
    logic        arr_val;
    logic        arr_write_enb;
    logic        arr_run;
    logic [15:0] arr_alive = 16'hA5C3;
    logic        res_valid;
    logic [15:0] res_data;
    logic        res_stable;
    logic        res_ready = 1'b0;
    logic        busy;
    logic [2:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rdy_mode = 1; // 0: hold low, 1: hold high, 2: random

    logic [W-1:0] exp_q[$];
    int           acc_q[$];

    life_pattern_loader #(.GENS_W(8)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pat_valid     (pat_valid),
        .pat_data      (pat_data),
        .pat_gens      (pat_gens),
        .pat_ready     (pat_ready),
        .arr_row       (arr_row),
        .arr_col       (arr_col),
        .arr_val       (arr_val),
        .arr_write_enb (arr_write_enb),
        .arr_run       (arr_run),
        .arr_alive     (arr_alive),
        .res_valid     (res_valid),
        .res_data      (res_data),
        .res_stable    (res_stable),
        .res_ready     (res_ready),
        .busy          (busy),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference Life rules (dead border) ----------------
    function automatic logic [15:0] life_step(input logic [15:0] s);
        logic [15:0] nx;
        nx = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                int n;
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if ((dr != 0 || dc != 0) && (r + dr) >= 0 && (r + dr) < 4 &&
                            (c + dc) >= 0 && (c + dc) < 4)
                            n += int'(s[4 * (c + dc) + (r + dr)]);
                    end
                end
                nx[4 * c + r] = (n == 3) || (s[4 * c + r] && n == 2);
            end
        end
        return nx;
    endfunction

    function automatic logic [16:0] life_ref(input logic [15:0] seed, input logic [7:0] gens);
        logic [15:0] g;
        logic [15:0] p;
        g = seed;
        p = seed;
        for (int i = 0; i < int'(gens); i++) begin
            p = g;
            g = life_step(g);
        end
        return {(gens != 0) && (g == p), g};
    endfunction

    // ---------------- behavioural array on the write/run port ----------------
    always @(posedge clk) begin
        if (arr_write_enb)
            arr_alive[{arr_col, arr_row}] <= arr_val;
        else if (arr_run)
            arr_alive <= life_step(arr_alive);
    end

    // ---------------- result-ready driver ----------------
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       res_ready = 1'b0;
                1:       res_ready = 1'b1;
                default: res_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [3:0]   wr_k = '0;
    int           wr_cnt = 0;
    int           run_cnt = 0;
    logic         prev_vld = 1'b0;
    logic [15:0]  last_data = '0;
    logic         last_stable = 1'b0;

    always @(negedge clk) begin
        logic [W-1:0] h;
        logic [15:0]  s;
        if (!reset_n) begin
            exp_q.delete();
            acc_q.delete();
            wr_k = '0;
            wr_cnt = 0;
            run_cnt = 0;
            prev_vld = 1'b0;
        end else begin
            chk("ready_vs_busy", {31'd0, pat_ready}, {31'd0, !busy});
            if (arr_write_enb || arr_run)
                chk("write_run_overlap", {31'd0, arr_write_enb && arr_run}, 32'd0);
            if (arr_write_enb) begin
                if (exp_q.size() == 0) begin
                    chk("write_unexpected", 32'd1, 32'd0);
                end else begin
                    h = exp_q[0];
                    s = h[32:17];
                    chk("write_cell", {28'd0, arr_col, arr_row}, {28'd0, wr_k});
                    chk("write_val", {31'd0, arr_val}, {31'd0, s[wr_k]});
                end
                wr_k = wr_k + 4'd1;
                wr_cnt++;
            end
            if (arr_run) run_cnt++;
            if (res_valid && !prev_vld) begin
                if (exp_q.size() == 0) begin
                    chk("result_unexpected", 32'd1, 32'd0);
                end else begin
                    h = exp_q[0];
                    chk("latency", 32'(cyc - acc_q[0]), 32'(int'(h[40:33]) + 18));
                    chk("write_count", 32'(wr_cnt), 32'd16);
                    chk("run_count", 32'(run_cnt), 32'(h[40:33]));
                end
            end
            if (res_valid && prev_vld) begin
                chk("hold_data", {16'd0, res_data}, {16'd0, last_data});
                chk("hold_stable", {31'd0, res_stable}, {31'd0, last_stable});
            end
            if (res_valid && res_ready && exp_q.size() != 0) begin
                h = exp_q.pop_front();
                void'(acc_q.pop_front());
                chk("res_data", {16'd0, res_data}, {16'd0, h[15:0]});
                chk("res_stable", {31'd0, res_stable}, {31'd0, h[16]});
                wr_k = '0;
                wr_cnt = 0;
                run_cnt = 0;
            end
            prev_vld = res_valid;
            last_data = res_data;
            last_stable = res_stable;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [15:0] seed, input logic [7:0] gens,
                        input logic [15:0] ed, input logic es);
        int  n;
        bit  got;
        n = 0;
        got = 0;
        @(posedge clk);
        #1;
        pat_valid = 1'b1;
        pat_data = seed;
        pat_gens = gens;
        while (!got && n < 2000) begin
            @(negedge clk);
            if (pat_ready) got = 1;
            else n++;
        end
        if (!got) begin
            chk("accept_timeout", 32'd1, 32'd0);
            pat_valid = 1'b0;
            return;
        end
        exp_q.push_back({gens, seed, es, ed});
        acc_q.push_back(cyc + 1);
        @(posedge clk);
        #1;
        pat_valid = 1'b0;
        pat_data = 16'($urandom);
        pat_gens = 8'($urandom);
    endtask

    task automatic send_rand(input logic [15:0] seed, input logic [7:0] gens);
        logic [16:0] r;
        r = life_ref(seed, gens);
        send(seed, gens, r[15:0], r[16]);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    logic [15:0] d_seed [9];
    logic [7:0]  d_gens [9];
    logic [15:0] d_res  [9];
    logic        d_stb  [9];

    initial begin
        logic [15:0] held;
        logic [15:0] seed_b;
        int          n;

        d_seed = '{16'h0222, 16'h0222, 16'h0222, 16'h0660, 16'h6996,
                   16'hCC33, 16'h6186, 16'h6186, 16'h0222};
        d_gens = '{8'd0, 8'd1, 8'd2, 8'd5, 8'd3, 8'd1, 8'd1, 8'd2, 8'd255};
        d_res  = '{16'h0222, 16'h0070, 16'h0222, 16'h0660, 16'h6996,
                   16'hC813, 16'h2664, 16'h6186, 16'h0070};
        d_stb  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        // reset
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_res_valid", {31'd0, res_valid}, 32'd0);
        chk("reset_write", {31'd0, arr_write_enb}, 32'd0);
        chk("reset_run", {31'd0, arr_run}, 32'd0);
        chk("reset_res_data", {16'd0, res_data}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("release_pat_ready", {31'd0, pat_ready}, 32'd1);

        // directed patterns
        rdy_mode = 1;
        for (int i = 0; i < 9; i++) send(d_seed[i], d_gens[i], d_res[i], d_stb[i]);
        drain();

        // randomized seeds and counts with random consumer stalls
        rdy_mode = 2;
        for (int i = 0; i < 25; i++) send_rand(16'($urandom), 8'($urandom_range(0, 12)));
        drain();

        // backpressure: result held while a new seed waits
        rdy_mode = 0;
        send_rand(16'($urandom), 8'd3);
        n = 0;
        while (!res_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("bp_res_valid", {31'd0, res_valid}, 32'd1);
        held = res_data;
        seed_b = 16'($urandom);
        @(posedge clk);
        #1;
        pat_valid = 1'b1;
        pat_data = seed_b;
        pat_gens = 8'd2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_pat_ready", {31'd0, pat_ready}, 32'd0);
            chk("bp_array_idle", {30'd0, arr_write_enb, arr_run}, 32'd0);
            chk("bp_held", {16'd0, res_data}, {16'd0, held});
        end
        @(posedge clk);
        #1;
        rdy_mode = 1;
        @(posedge clk); // result handshake edge
        #3;
        chk("bp_release_valid", {31'd0, res_valid}, 32'd0);
        chk("bp_release_ready", {31'd0, pat_ready}, 32'd1);
        begin
            logic [16:0] r;
            r = life_ref(seed_b, 8'd2);
            exp_q.push_back({8'd2, seed_b, r[16], r[15:0]});
            acc_q.push_back(cyc + 1);
        end
        @(posedge clk); // accept edge
        #1;
        chk("bp_accept_busy", {31'd0, busy}, 32'd1);
        chk("bp_accept_write", {31'd0, arr_write_enb}, 32'd1);
        pat_valid = 1'b0;
        drain();

        // asynchronous reset in the middle of RUN
        send_rand(16'h0660, 8'd100);
        n = 0;
        while (!arr_run && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("midrun_reached", {31'd0, arr_run}, 32'd1);
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_run", {31'd0, arr_run}, 32'd0);
        chk("async_write", {31'd0, arr_write_enb}, 32'd0);
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_res_valid", {31'd0, res_valid}, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_ready", {31'd0, pat_ready}, 32'd1);
        chk("post_reset_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_reset_run", {31'd0, arr_run}, 32'd0);
        end

        // recovery after abandoned run
        send(16'h0222, 8'd1, 16'h0070, 1'b0);
        drain();

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
